// File: rtl/mod_delay_pkg.sv
// rtl/mod_delay_pkg.sv - shared FSM state type and default sizes for the modulated delay reader
// Purpose: single home for the reader FSM encoding and the default sample width / buffer depth.
// Ports: none (package).
package mod_delay_pkg;

  localparam int DW_DEFAULT         = 16;
  localparam int DEPTH_LOG2_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    READ   = 2'd2,
    OUTPUT = 2'd3
  } state_t;

endpackage

// File: rtl/sdp_ram_sync.sv
// rtl/sdp_ram_sync.sv - simple dual-port RAM, one write port, one registered read port, no reset
// Purpose: delay-line storage; read data appears the cycle after the read address is presented.
// Ports:
//   clk   - clock, rising edge
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address, sampled every cycle
//   rdata - registered read data
module sdp_ram_sync #(
  parameter int DW = 16,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mod_delay_reader.sv
// rtl/mod_delay_reader.sv - LFO-modulated delay line reader (vibrato, optional dry mix for chorus)
// Purpose: accepts one audio sample per transaction, stores it in a circular buffer and returns the
//   sample D positions older (D from the LFO, clamped to buffer depth). Four cycles per sample.
// Build option: define MOD_DELAY_MIX_DRY_EN to output (dry + wet) >>> 1 instead of wet only.
// Ports:
//   CLK          - system clock, rising edge
//   RST          - synchronous active-high reset
//   sample_in    - dry sample (two's complement)
//   sample_valid - one-cycle strobe for sample_in; ignored (and flagged) while busy
//   mod          - delay in samples from the LFO, sampled at acceptance
//   sample_out   - delayed (or mixed) sample, held between out_valid pulses
//   out_valid    - one-cycle strobe for sample_out
//   busy         - high while a sample is in flight
//   overrun      - sticky: a sample_valid arrived while busy
module mod_delay_reader
  import mod_delay_pkg::*;
#(
  parameter int DW         = DW_DEFAULT,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEFAULT
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [DW-1:0] sample_in,
  input  logic          sample_valid,
  input  logic [31:0]   mod,
  output logic [DW-1:0] sample_out,
  output logic          out_valid,
  output logic          busy,
  output logic          overrun
);

  localparam int AW    = DEPTH_LOG2;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t          state, state_next;
  logic            ram_we;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_addr;
  logic [AW:0]     fill;
  logic [AW-1:0]   delay_q;
  logic [AW-1:0]   delay_next;
  logic [DW-1:0]   dry_q;
  logic [DW-1:0]   rd_data;
  logic [DW-1:0]   wet;
  logic [DW-1:0]   result;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    ram_we     = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (sample_valid) begin
          state_next = WRITE;
        end
      end
      WRITE: begin
        ram_we     = 1'b1;
        state_next = READ;
      end
      READ:    state_next = OUTPUT;
      OUTPUT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Delays beyond the buffer collapse to the oldest stored sample.
  always_comb begin
    delay_next = '1;
    if (mod < 32'(DEPTH)) begin
      delay_next = mod[AW-1:0];
    end
  end

  // In READ, wr_ptr has already advanced past the sample just written, so step back one extra.
  assign rd_addr = wr_ptr - AW'(1) - delay_q;

  sdp_ram_sync #(
    .DW (DW),
    .AW (AW)
  ) u_ram (
    .clk   (CLK),
    .we    (ram_we),
    .waddr (wr_ptr),
    .wdata (dry_q),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // fill already counts the current sample by OUTPUT, so D=0 is always valid; older slots may be stale.
  assign wet = ({1'b0, delay_q} < fill) ? rd_data : '0;

`ifdef MOD_DELAY_MIX_DRY_EN
  logic signed [DW:0] mix_sum;
  assign mix_sum = $signed({dry_q[DW-1], dry_q}) + $signed({wet[DW-1], wet});
  assign result  = mix_sum[DW:1];
`else
  assign result = wet;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr     <= '0;
      fill       <= '0;
      sample_out <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      dry_q      <= '0;
      delay_q    <= '0;
    end else begin
      out_valid <= 1'b0;
      if (state == IDLE && sample_valid) begin
        dry_q   <= sample_in;
        delay_q <= delay_next;
      end
      if (state != IDLE && sample_valid) begin
        overrun <= 1'b1;
      end
      if (state == WRITE) begin
        wr_ptr <= wr_ptr + AW'(1);
        if (fill != (AW+1)'(DEPTH)) begin
          fill <= fill + (AW+1)'(1);
        end
      end
      if (state == OUTPUT) begin
        sample_out <= result;
        out_valid  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mod_delay_reader.sv
// tb/tb_mod_delay_reader.sv - scoreboard bench for mod_delay_reader (default parameters)
module tb_mod_delay_reader;

  logic        CLK;
  logic        RST;
  logic [15:0] sample_in;
  logic        sample_valid;
  logic [31:0] mod;
  logic [15:0] sample_out;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  mod_delay_reader dut (
    .CLK          (CLK),
    .RST          (RST),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .mod          (mod),
    .sample_out   (sample_out),
    .out_valid    (out_valid),
    .busy         (busy),
    .overrun      (overrun)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mbuf [1024];
  int          mptr;
  int          mfill;
  int          cyc;
  int          n_cmp;
  int          n_bad;
  logic [15:0] prev_out;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: advance to the falling edge, then score whatever the DUT shows there.
  task automatic step();
    exp_t e;
    @(negedge CLK);
    cyc++;
    if (out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_out_valid", 32'(sample_out), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("sample_out", 32'(sample_out), 32'(e.data));
        chk("latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end else if (RST !== 1'b1 && cyc > 2) begin
      chk("hold_between_pulses", 32'(sample_out), 32'(prev_out));
    end
    prev_out = sample_out;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [15:0] data, input int m);
    int          d;
    logic [15:0] w;
    logic [16:0] s;
    exp_t        e;
    d = (m < 1024) ? m : 1023;
    mbuf[mptr] = data;
    if (mfill < 1024) mfill++;
    w = (d < mfill) ? mbuf[(mptr - d) & 1023] : 16'h0;
`ifdef MOD_DELAY_MIX_DRY_EN
    s = {data[15], data} + {w[15], w};
    e.data = s[16:1];
`else
    s = '0;
    e.data = w;
`endif
    mptr = (mptr + 1) & 1023;
    e.cyc = cyc + 4;
    sb.push_back(e);
    sample_in    = data;
    mod          = 32'(m);
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step();
    RST = 1'b0;
    mptr  = 0;
    mfill = 0;
    sb.delete();
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() > 0; i++) step();
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    cyc = 0; n_cmp = 0; n_bad = 0; mptr = 0; mfill = 0; prev_out = '0;
    RST = 1'b1; sample_valid = 1'b0; sample_in = '0; mod = '0;
    step();
    step();
    chk("rst_sample_out", 32'(sample_out), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    RST = 1'b0;

    // D=0 returns the sample just written, four cycles after the strobe.
    send(16'h1234, 0);
    chk("busy_in_flight", 32'(busy), 32'd1);
    idle(5);
    drain();

    // Ramp with a 5-sample lag.
    do_reset();
    for (int i = 1; i <= 12; i++) begin
      send(16'(i), 5);
      idle(7);
    end
    drain();

    // Overrun: second strobe two cycles after the first is dropped.
    do_reset();
    chk("overrun_clear", 32'(overrun), 32'd0);
    send(16'h0055, 7);
    step();
    sample_in = 16'h0066; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    chk("overrun_set", 32'(overrun), 32'd1);
    idle(6);
    send(16'h0077, 1);
    idle(6);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    drain();
    do_reset();
    chk("overrun_reset", 32'(overrun), 32'd0);

    // Dry/wet pairs.
    send(16'd300, 0);   idle(3);
    send(16'hFF9C, 1);  idle(3);
    send(16'h7FFF, 0);  idle(3);
    send(16'h7FFF, 1);  idle(6);
    drain();

    // Reset while the sample sits in READ; strobe during reset is ignored.
    do_reset();
    send(16'hAAAA, 0);  idle(3);
    sample_in = 16'hBBBB; mod = 32'd0; sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    step();
    RST = 1'b1; sample_valid = 1'b1; sample_in = 16'hCCCC;
    step();
    RST = 1'b0; sample_valid = 1'b0;
    mptr = 0; mfill = 0; sb.delete();
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sample_out", 32'(sample_out), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    idle(6);
    send(16'h4321, 3);
    idle(6);
    drain();

    // Clamp to 1023 and wrap the write pointer, at minimum spacing.
    do_reset();
    for (int i = 1; i <= 1100; i++) begin
      send(16'(i), 2000);
      idle(3);
    end
    idle(2);
    drain();
    chk("no_overrun_min_spacing", 32'(overrun), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
